// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Watches a free-running binary counter and logs two kinds of event into a
//   small FIFO, each stamped with a cycle timestamp:
//     wrap  : previous sample all-ones and current sample zero
//     match : current sample equals match_val and differs from the previous one
//   The FIFO drains over a valid/ready port.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   arm         1 = monitor enabled, 0 = return to IDLE
//   count_in    sampled counter value
//   match_val   match compare value (quasi-static)
//   evt_valid   FIFO head valid
//   evt_ready   consumer accepts head on evt_valid & evt_ready
//   evt_data    {type[1:0], count[CNT_W-1:0], ts[TS_W-1:0]}, zero when empty
//   overflow    sticky: an event was dropped because the FIFO was full
//   busy        state != IDLE
//   drop_count  (only with CNT_MON_DROP_CNT_EN) saturating count of dropped events
//
// Build option
//   CNT_MON_DROP_CNT_EN : adds the drop_count output and its counter.

module count_event_monitor #(
    parameter int CNT_W = 6,
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic [CNT_W-1:0]          count_in,
    input  logic [CNT_W-1:0]          match_val,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [2+CNT_W+TS_W-1:0]   evt_data,
    output logic                      overflow,
    output logic                      busy
`ifdef CNT_MON_DROP_CNT_EN
    ,
    output logic [7:0]                drop_count
`endif
);

    localparam int REC_W = 2 + CNT_W + TS_W;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, MONITOR} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       prev_q, prev_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    logic [REC_W-1:0]       mem_q [DEPTH];
    logic [REC_W-1:0]       mem_d [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
`ifdef CNT_MON_DROP_CNT_EN
    logic [7:0]             drop_q, drop_d;
`endif

    logic empty, full, pop, wrap_hit, match_hit, detect;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        ts_d       = ts_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
`ifdef CNT_MON_DROP_CNT_EN
        drop_d     = drop_q;
`endif

        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop   = !empty && evt_ready;

        // Detection runs for the whole MONITOR cycle, including the one in
        // which arm drops; it stops once the state has left MONITOR.
        detect    = (state_q == MONITOR);
        wrap_hit  = detect && (prev_q == '1) && (count_in == '0);
        // Edge-qualified so a stalled count is logged only once.
        match_hit = detect && (count_in == match_val) && (count_in != prev_q);

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = PRIME;
                    overflow_d = 1'b0;
`ifdef CNT_MON_DROP_CNT_EN
                    drop_d     = '0;
`endif
                end
            end
            PRIME: begin
                prev_d  = count_in;
                ts_d    = '0;
                state_d = arm ? MONITOR : IDLE;
            end
            MONITOR: begin
                prev_d  = count_in;
                ts_d    = ts_q + TS_W'(1);
                state_d = arm ? MONITOR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop)
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (wrap_hit || match_hit) begin
            if (!full || pop) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = {wrap_hit, match_hit, count_in, ts_q};
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end else begin
                overflow_d = 1'b1;
`ifdef CNT_MON_DROP_CNT_EN
                if (drop_q != 8'hFF)
                    drop_d = drop_q + 8'd1;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
`ifdef CNT_MON_DROP_CNT_EN
            drop_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
`ifdef CNT_MON_DROP_CNT_EN
            drop_q     <= drop_d;
`endif
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);
`ifdef CNT_MON_DROP_CNT_EN
    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: a vector table for the basic match/wrap
// cases, hand-written sequences for FIFO full, overflow, drain and async
// reset, and a reference model feeding a scoreboard queue of expected records.

module tb_count_event_monitor;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic [5:0]  count_in;
    logic [5:0]  match_val;
    logic        evt_valid;
    logic        evt_ready;
    logic [23:0] evt_data;
    logic        overflow;
    logic        busy;
`ifdef CNT_MON_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    count_event_monitor dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .count_in  (count_in),
        .match_val (match_val),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .overflow  (overflow),
        .busy      (busy)
`ifdef CNT_MON_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 IDLE, 1 PRIME, 2 MONITOR
    int          m_st   = 0;
    logic [5:0]  m_prev = '0;
    logic [15:0] m_ts   = '0;
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;
    logic [23:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic a, input logic [5:0] c, input logic [5:0] m, input logic r);
        logic        w, mt;
        logic [23:0] exp_rec;
        arm = a; count_in = c; match_val = m; evt_ready = r;
        #1;
        if (sb_q.size() > 0 && r) begin
            exp_rec = sb_q.pop_front();
            chk("evt_data_pop", {8'h0, evt_data}, {8'h0, exp_rec});
        end
        if (m_st == 2) begin
            w  = (m_prev == 6'd63) && (c == 6'd0);
            mt = (c == m) && (c != m_prev);
            if (w || mt) begin
                if (sb_q.size() < DEPTH) sb_q.push_back({w, mt, c, m_ts});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        case (m_st)
            0: if (a) begin m_st = 1; m_ovf = 1'b0; m_drop = 0; end
            1: begin m_prev = c; m_ts = '0; m_st = a ? 2 : 0; end
            default: begin m_prev = c; m_ts = m_ts + 16'd1; m_st = a ? 2 : 0; end
        endcase
        @(posedge clock);
        #1;
        chk("evt_valid", {31'h0, evt_valid}, {31'h0, sb_q.size() != 0});
        chk("busy", {31'h0, busy}, {31'h0, m_st != 0});
        chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        if (sb_q.size() == 0) chk("evt_data_empty", {8'h0, evt_data}, 32'h0);
`ifdef CNT_MON_DROP_CNT_EN
        chk("drop_count", {24'h0, drop_count}, m_drop);
`endif
    endtask

    typedef struct {
        logic       a;
        logic [5:0] c;
        logic [5:0] m;
        logic       r;
        logic       exp_vld;
        logic [1:0] exp_type;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int          n_pop;
        logic [15:0] last_ts;
        logic        have_ts;

        tbl = '{
            '{1, 3, 5, 1, 0, 2'b00},   // IDLE -> PRIME
            '{1, 3, 5, 1, 0, 2'b00},   // PRIME -> MONITOR
            '{1, 4, 5, 1, 0, 2'b00},
            '{1, 5, 5, 1, 1, 2'b01},   // match, visible next cycle
            '{1, 5, 5, 1, 0, 2'b00},   // stalled count: no second record
            '{1, 6, 5, 1, 0, 2'b00},
            '{1, 62, 40, 1, 0, 2'b00},
            '{1, 63, 40, 1, 0, 2'b00},
            '{1, 0, 40, 1, 1, 2'b10},  // wrap
            '{1, 1, 40, 1, 0, 2'b00},
            '{1, 17, 40, 1, 0, 2'b00},
            '{1, 0, 40, 1, 0, 2'b00},  // counter reset 17->0 is not a wrap
            '{1, 63, 0, 1, 0, 2'b00},
            '{1, 0, 0, 1, 1, 2'b11},   // wrap + match in one record
            '{1, 1, 0, 1, 0, 2'b00}
        };

        reset = 1'b0; arm = 1'b0; count_in = '0; match_val = '0; evt_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'h0, evt_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_data", {8'h0, evt_data}, 32'h0);
        reset = 1'b1;

        // Table: match, stalled match, wrap, counter-reset non-wrap, both.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].a, tbl[i].c, tbl[i].m, tbl[i].r);
            chk($sformatf("tbl%0d_vld", i), {31'h0, evt_valid}, {31'h0, tbl[i].exp_vld});
            if (tbl[i].exp_vld)
                chk($sformatf("tbl%0d_type", i), {30'h0, evt_data[23:22]}, {30'h0, tbl[i].exp_type});
        end

        // Five events with the consumer stalled: four held, one dropped.
        for (int i = 0; i < 9; i++)
            step(1, (i % 2 == 0) ? 6'd10 : 6'd11, 6'd10, 0);
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_held", {31'h0, evt_valid}, 32'h1);
`ifdef CNT_MON_DROP_CNT_EN
        chk("ovf_drop1", {24'h0, drop_count}, 32'h1);
`endif
        n_pop = 0; have_ts = 1'b0; last_ts = '0;
        for (int i = 0; i < 6; i++) begin
            if (evt_valid) begin
                n_pop++;
                if (have_ts)
                    chk("ts_increasing", {31'h0, evt_data[15:0] > last_ts}, 32'h1);
                last_ts = evt_data[15:0];
                have_ts = 1'b1;
            end
            step(1, 6'd11, 6'd10, 1);
        end
        chk("drain_cnt", n_pop, 4);

        // Re-arm clears overflow; then full FIFO with push+pop in one cycle.
        step(0, 6'd11, 6'd10, 1);
        step(1, 6'd11, 6'd10, 1);
        chk("ovf_clear_prime", {31'h0, overflow}, 32'h0);
        step(1, 6'd11, 6'd10, 1);
        for (int i = 0; i < 8; i++)
            step(1, (i % 2 == 0) ? 6'd10 : 6'd11, 6'd10, 0);
        chk("full_depth", sb_q.size(), DEPTH);
        step(1, 6'd10, 6'd10, 1);
        chk("pushpop_no_ovf", {31'h0, overflow}, 32'h0);
        chk("pushpop_depth", sb_q.size(), DEPTH);
        step(0, 6'd11, 6'd10, 1);
        chk("disarm_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 6; i++)
            step(0, 6'd10, 6'd10, 1);
        chk("drained_valid", {31'h0, evt_valid}, 32'h0);
        chk("drained_sb", sb_q.size(), 0);

        // Async reset with records queued and overflow set.
        step(1, 6'd11, 6'd10, 0);
        step(1, 6'd11, 6'd10, 0);
        for (int i = 0; i < 10; i++)
            step(1, (i % 2 == 0) ? 6'd10 : 6'd11, 6'd10, 0);
        chk("pre_rst_ovf", {31'h0, overflow}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, evt_valid}, 32'h0);
        chk("arst_ovf", {31'h0, overflow}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_data", {8'h0, evt_data}, 32'h0);
        sb_q.delete();
        m_st = 0; m_prev = '0; m_ts = '0; m_ovf = 1'b0; m_drop = 0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(0, 6'd0, 6'd10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
